s2_sched_ctrl: RTL and testbench
================================

S2_SCHED_CTRL -- requirements
Module: s2_sched_ctrl

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32: width of all signed operands, intermediates and results.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: request one evaluation; sampled only in IDLE.
REQ-005 SHALL have ports a, b, c, input, DATAWIDTH each, signed: operands, captured on the accepted-start edge.
REQ-006 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-007 SHALL have port done, output, 1: one-cycle pulse when x and z update.
REQ-008 SHALL have ports x, z, output, DATAWIDTH each, signed: registered results, held until the next done.
REQ-009 SHALL have port ovf, output, 1, present only with SCHED_OVF_EN: sticky signed-overflow flag.

Function
REQ-010 SHALL evaluate the dataflow on one shared add/sub/shift unit: d=a+b, e=a+c, f=a-b, lt=(d<e), eq=(d==e), g=lt?e:d, h=eq?f:g, x=g<<lt, z=h>>>eq.
REQ-011 SHALL use signed two's-complement arithmetic modulo 2^DATAWIDTH: wrap on overflow, signed compare, arithmetic right shift.
REQ-012 SHALL implement FSM states IDLE -> S_D -> S_E -> S_F -> S_CMP -> S_SH -> IDLE, advancing one state per cycle unconditionally outside IDLE.
REQ-013 SHALL leave IDLE only when start=1 on a clock edge, and SHALL capture a, b, c on that same edge.
REQ-014 SHALL register d in S_D, e in S_E, f in S_F, and lt, eq, g, h in S_CMP.
REQ-015 SHALL update x and z and raise done at the S_SH edge: done=1 exactly 5 cycles after the accepting edge.
REQ-016 SHALL ignore start while busy=1, with no queuing.
REQ-017 SHALL accept start in the cycle where done=1, because the FSM is then in IDLE; back-to-back evaluations therefore have a 6-cycle period.
REQ-018 SHALL keep x and z stable outside the done edge, and SHALL keep operand changes after capture from affecting the run.

Reset
REQ-019 While rst=0, SHALL force state=IDLE, busy=0, done=0, x=0, z=0, all intermediates=0, and ovf=0.
REQ-020 SHALL abort any run in progress when reset is asserted mid-operation, with no done pulse and x/z cleared to 0.
REQ-021 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-022 SHALL compile the overflow monitor in when macro SCHED_OVF_EN is defined.
REQ-023 With SCHED_OVF_EN, SHALL set ovf when d, e, f or x overflows signed range, and SHALL clear ovf only on reset or on an accepted start.
REQ-024 Without SCHED_OVF_EN, SHALL omit the ovf port and logic, with identical cycle behaviour for all other ports.

Structure
REQ-025 SHALL take from shared package sched_pkg: state enum (IDLE, S_D, S_E, S_F, S_CMP, S_SH), ALU op enum (OP_ADD, OP_SUB, OP_SHL, OP_SHR), and constant SCHED_LATENCY=5.
REQ-026 SHALL instantiate one sub-module, sched_alu, which is combinational, takes DATAWIDTH, two operands and an op, and returns a result and a signed-overflow bit.
REQ-027 SHALL drive the sched_alu operands and op from the FSM state through operand muxes.

Verification
REQ-028 Basic run: a=5, b=3, c=10, start pulse -> done after 5 cycles; x=30, z=15; busy high 5 cycles.
REQ-029 Equal compare: a=4, b=6, c=6 -> eq=1, lt=0; x=10, z=-1 (h=f=-2, arithmetic shift).
REQ-030 Overflow wrap: a=0x7FFFFFFF, b=1, c=0 -> d=0x80000000, lt=1; x=0xFFFFFFFE, z=0x7FFFFFFF; ovf=1 with SCHED_OVF_EN.
REQ-031 Start while busy: start held high for 12 cycles -> exactly two runs, done at cycles 5 and 11, second run uses operands present at cycle 6.
REQ-032 Mid-run reset: assert rst=0 in S_F -> busy=0, x=z=0, no done pulse; new start after release -> correct result 5 cycles later.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types and constants for the s2 scheduled datapath controller.
package sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_D   = 3'd1,
        S_E   = 3'd2,
        S_F   = 3'd3,
        S_CMP = 3'd4,
        S_SH  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_SHL = 2'd2,
        OP_SHR = 2'd3
    } alu_op_e;

    // Cycles from the accepting edge to the done pulse.
    localparam int unsigned SCHED_LATENCY = 5;

endpackage

// File: rtl/sched_alu.sv
// Combinational add/sub/shift unit shared by every scheduled step.
module sched_alu
    import sched_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic signed [DATAWIDTH-1:0] op_a,
    input  logic signed [DATAWIDTH-1:0] op_b,
    input  alu_op_e                     op,
    output logic signed [DATAWIDTH-1:0] res,
    output logic                        ovf
);

    localparam int unsigned MSB = DATAWIDTH - 1;

    // Wrapping result plus a signed-overflow indication for the selected op.
    always_comb begin
        res = '0;
        ovf = 1'b0;
        unique case (op)
            OP_ADD: begin
                res = op_a + op_b;
                ovf = (op_a[MSB] == op_b[MSB]) && (res[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                res = op_a - op_b;
                ovf = (op_a[MSB] != op_b[MSB]) && (res[MSB] != op_a[MSB]);
            end
            OP_SHL: begin
                res = op_a <<< op_b;
                // Any bit shifted out that disagrees with the new sign is lost range.
                ovf = (res >>> op_b) != op_a;
            end
            OP_SHR: begin
                res = op_a >>> op_b;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/s2_sched_ctrl.sv
// Multi-cycle evaluation of x/z over one shared ALU, one step per state.
// Optional sticky overflow output enabled by defining SCHED_OVF_EN.
module s2_sched_ctrl
    import sched_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic signed [DATAWIDTH-1:0] a,
    input  logic signed [DATAWIDTH-1:0] b,
    input  logic signed [DATAWIDTH-1:0] c,
    output logic                        busy,
    output logic                        done,
    output logic signed [DATAWIDTH-1:0] x,
    output logic signed [DATAWIDTH-1:0] z
`ifdef SCHED_OVF_EN
    ,
    output logic                        ovf
`endif
);

    localparam int unsigned MSB = DATAWIDTH - 1;

    state_e                      state_q, state_d;
    logic signed [DATAWIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic signed [DATAWIDTH-1:0] d_q, d_d, e_q, e_d, f_q, f_d;
    logic signed [DATAWIDTH-1:0] g_q, g_d, h_q, h_d;
    logic signed [DATAWIDTH-1:0] x_q, x_d, z_q, z_d;
    logic                        lt_q, lt_d, eq_q, eq_d;
    logic                        busy_q, busy_d, done_q, done_d;

    logic signed [DATAWIDTH-1:0] alu_a, alu_b, alu_res;
    alu_op_e                     alu_op;
    logic                        alu_ovf;

    sched_alu #(.DATAWIDTH(DATAWIDTH)) u_alu (
        .op_a (alu_a),
        .op_b (alu_b),
        .op   (alu_op),
        .res  (alu_res),
        .ovf  (alu_ovf)
    );

    // Operand/op selection for the shared ALU, keyed on the current step.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_ADD;
        unique case (state_q)
            S_D:   begin alu_a = a_q; alu_b = b_q; alu_op = OP_ADD; end
            S_E:   begin alu_a = a_q; alu_b = c_q; alu_op = OP_ADD; end
            S_F:   begin alu_a = a_q; alu_b = b_q; alu_op = OP_SUB; end
            S_CMP: begin alu_a = d_q; alu_b = e_q; alu_op = OP_SUB; end
            S_SH:  begin alu_a = g_q; alu_b = {{(DATAWIDTH-1){1'b0}}, lt_q}; alu_op = OP_SHL; end
            default: ;
        endcase
    end

    // Next state and datapath register updates.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        e_d     = e_q;
        f_d     = f_q;
        g_d     = g_q;
        h_d     = h_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        x_d     = x_q;
        z_d     = z_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = S_D;
                    a_d     = a;
                    b_d     = b;
                    c_d     = c;
                end
            end
            S_D: begin
                state_d = S_E;
                d_d     = alu_res;
            end
            S_E: begin
                state_d = S_F;
                e_d     = alu_res;
            end
            S_F: begin
                state_d = S_CMP;
                f_d     = alu_res;
            end
            S_CMP: begin
                state_d = S_SH;
                // d<e from the sign of d-e corrected by its overflow; wrap keeps equality exact.
                lt_d    = alu_res[MSB] ^ alu_ovf;
                eq_d    = (alu_res == '0);
                g_d     = lt_d ? e_q : d_q;
                h_d     = eq_d ? f_q : g_d;
            end
            S_SH: begin
                state_d = IDLE;
                x_d     = alu_res;
                // A one-place arithmetic shift is pure wiring, so it stays off the ALU.
                z_d     = eq_q ? {h_q[MSB], h_q[MSB:1]} : h_q;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            f_q     <= '0;
            g_q     <= '0;
            h_q     <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            x_q     <= '0;
            z_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            e_q     <= e_d;
            f_q     <= f_d;
            g_q     <= g_d;
            h_q     <= h_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            x_q     <= x_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign x    = x_q;
    assign z    = z_q;

`ifdef SCHED_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky flag: cleared by an accepted start, set by d/e/f/x overflow.
    always_comb begin
        ovf_d = ovf_q;
        if ((state_q == IDLE) && start) begin
            ovf_d = 1'b0;
        end else if (alu_ovf && ((state_q == S_D) || (state_q == S_E) ||
                                 (state_q == S_F) || (state_q == S_SH))) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    // No overflow monitor in this build; the compare step still consumes alu_ovf.
`endif

endmodule

// File: tb/tb_s2_sched_ctrl.sv
// Scoreboard bench for s2_sched_ctrl against an arithmetic reference model.
module tb_s2_sched_ctrl;

    logic               clk;
    logic               rst;
    logic               start;
    logic signed [31:0] a, b, c;
    logic               busy, done;
    logic signed [31:0] x, z;
`ifdef SCHED_OVF_EN
    logic               ovf;
`endif

    s2_sched_ctrl #(.DATAWIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .busy  (busy),
        .done  (done),
        .x     (x),
        .z     (z)
`ifdef SCHED_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int z;
        bit ov;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t ex;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   busy_left = 0;
    int   hold_x = 0, hold_z = 0, run_x = 0, run_z = 0;
    int   done_cnt = 0;

    // Reference evaluation straight from the dataflow equations, using wide arithmetic.
    function automatic void ref_eval(input int ia, input int ib, input int ic,
                                     output int ox, output int oz, output bit ov);
        longint sd, se, sf, sx;
        int     d, e, f, g, h;
        bit     lt, eq;
        sd = longint'(ia) + longint'(ib);
        se = longint'(ia) + longint'(ic);
        sf = longint'(ia) - longint'(ib);
        d  = int'(sd);
        e  = int'(se);
        f  = int'(sf);
        ov = (longint'(d) != sd) || (longint'(e) != se) || (longint'(f) != sf);
        lt = (d < e);
        eq = (d == e);
        g  = lt ? e : d;
        h  = eq ? f : g;
        sx = lt ? 2 * longint'(g) : longint'(g);
        ox = int'(sx);
        ov = ov || (longint'(ox) != sx);
        oz = eq ? int'((longint'(h) - longint'(h & 1)) / 2) : h;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Model: acceptance/busy timeline and expected results pushed at the accepting edge.
    always @(posedge clk) begin
        int  ex_x, ex_z;
        bit  ex_ov;
        cyc++;
        if (!rst) begin
            busy_left = 0;
            hold_x    = 0;
            hold_z    = 0;
            sb.delete();
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                hold_x = run_x;
                hold_z = run_z;
            end
        end else if (start) begin
            ref_eval(a, b, c, ex_x, ex_z, ex_ov);
            run_x     = ex_x;
            run_z     = ex_z;
            busy_left = 5;
            sb.push_back('{x: ex_x, z: ex_z, ov: ex_ov, cyc: cyc + 5});
        end
    end

    // Monitor: compares outputs away from the active edge and pops on done.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_x", x, 32'd0);
            chk("rst_z", z, 32'd0);
`ifdef SCHED_OVF_EN
            chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        end else begin
            chk("busy", 32'(busy), 32'(busy_left > 0));
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    ex = sb.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(ex.cyc));
                    chk("x", x, ex.x);
                    chk("z", z, ex.z);
`ifdef SCHED_OVF_EN
                    chk("ovf", 32'(ovf), 32'(ex.ov));
`endif
                end
            end else begin
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    ex = sb.pop_front();
                    chk("missed_done", 32'd0, 32'd1);
                end
                chk("x_hold", x, hold_x);
                chk("z_hold", z, hold_z);
            end
        end
    end

    task automatic rand_ops();
        int corner[5];
        corner = '{32'h7FFF_FFFF, 32'h8000_0000, -1, 0, 1};
        a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
        b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
        c = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
    endtask

    task automatic run_one(input int ia, input int ib, input int ic);
        a = ia; b = ib; c = ic; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rand_ops();
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        rst = 1'b0; start = 1'b0; a = 0; b = 0; c = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        run_one(5, 3, 10);
        run_one(4, 6, 6);
        run_one(32'h7FFF_FFFF, 1, 0);

        // Start held for 12 edges while operands change every cycle.
        base  = done_cnt;
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("held_start_runs", 32'(done_cnt - base), 32'd2);

        // Reset while the run sits in S_F, then restart on the first edge after release.
        base = done_cnt;
        a = 5; b = 3; c = 10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("aborted_no_done", 32'(done_cnt - base), 32'd0);
        rst = 1'b1; a = 4; b = 6; c = 6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("restart_done", 32'(done_cnt - base), 32'd1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rand_ops();
            start = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
